// File: rtl/sal_ddr2_pkg.sv
// Shared DDR2 definitions: the command encoding, default bus geometry and
// the sizing helper for the inter-bank timing counters.
package sal_ddr2_pkg;

  typedef enum logic [1:0] {
    CMD_ACT = 2'd0,
    CMD_RD  = 2'd1,
    CMD_WR  = 2'd2,
    CMD_PRE = 2'd3
  } cmd_t;

  localparam int BK_CNT_DEF = 8;
  localparam int ADDR_W_DEF = 14;

  // Width that holds the largest timing value (and zero).
  function automatic int tcnt_width(input int trrd, input int tccd, input int tfaw);
    int m;
    m = trrd;
    if (tccd > m) m = tccd;
    if (tfaw > m) m = tfaw;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/sal_cmd_scheduler_if.sv
// Bank-request and command-bus bundle of the DDR2 command scheduler.
// The scheduler uses the slave modport; the bank/bus side uses master.
interface sal_cmd_scheduler_if
  import sal_ddr2_pkg::*;
#(
  parameter int BK_CNT = BK_CNT_DEF,
  parameter int ADDR_W = ADDR_W_DEF
);
  localparam int BA_W = (BK_CNT > 1) ? $clog2(BK_CNT) : 1;

  logic [BK_CNT-1:0]        req_valid;
  logic [2*BK_CNT-1:0]      req_cmd;
  logic [ADDR_W*BK_CNT-1:0] req_addr;
  logic [BK_CNT-1:0]        req_gnt;
  logic                     cmd_valid;
  logic [1:0]               cmd_type;
  logic [BA_W-1:0]          cmd_ba;
  logic [ADDR_W-1:0]        cmd_addr;

  modport master (
    output req_valid, req_cmd, req_addr,
    input  req_gnt, cmd_valid, cmd_type, cmd_ba, cmd_addr
  );

  modport slave (
    input  req_valid, req_cmd, req_addr,
    output req_gnt, cmd_valid, cmd_type, cmd_ba, cmd_addr
  );
endinterface

// File: rtl/sal_rr_arbiter.sv
// Generic masked round-robin picker: returns the first request at or after
// ptr_i (wrapping), as a one-hot grant plus its index.
module sal_rr_arbiter #(
  parameter int N  = 8,
  parameter int IW = 3
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] ptr_i,
  output logic [N-1:0]  gnt_o,
  output logic [IW-1:0] idx_o,
  output logic          any_o
);
  logic [N-1:0] hi_mask;
  logic [N-1:0] masked;
  logic [N-1:0] use_vec;

  for (genvar gi = 0; gi < N; gi++) begin : g_mask
    assign hi_mask[gi] = (IW'(gi) >= ptr_i);
  end

  assign masked  = req_i & hi_mask;
  assign use_vec = (|masked) ? masked : req_i;
  assign any_o   = |req_i;

  // Lowest set bit of the (possibly wrapped) candidate vector wins.
  always_comb begin
    idx_o = '0;
    gnt_o = '0;
    for (int k = N - 1; k >= 0; k--) begin
      if (use_vec[k]) idx_o = IW'(k);
    end
    if (any_o) gnt_o[idx_o] = 1'b1;
  end
endmodule

// File: rtl/sal_cmd_scheduler.sv
// DDR2 command-bus scheduler: grants one bank command per cycle with
// priority column > PRE > ACT, round-robin within a class, enforcing tRRD
// and tCCD. Defining SAL_TFAW_EN adds the four-activate window (tFAW).
module sal_cmd_scheduler
  import sal_ddr2_pkg::*;
#(
  parameter int BK_CNT = BK_CNT_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int TRRD   = 2,
  parameter int TCCD   = 2,
  parameter int TFAW   = 10
) (
  input logic               clk,
  input logic               rst_n,
  sal_cmd_scheduler_if.slave bus
);
  localparam int BA_W  = (BK_CNT > 1) ? $clog2(BK_CNT) : 1;
  localparam int CNT_W = tcnt_width(TRRD, TCCD, TFAW);

  logic [1:0]        cmd_arr  [BK_CNT];
  logic [ADDR_W-1:0] addr_arr [BK_CNT];
  logic [BK_CNT-1:0] act_req, col_req, pre_req, sel_req;
  logic [BK_CNT-1:0] arb_gnt;
  logic [BA_W-1:0]   arb_idx;
  logic              arb_any;
  logic              act_ok, col_ok;
  logic              act_g, col_g;

  logic              cmd_valid_q, cmd_valid_d;
  logic [1:0]        cmd_type_q, cmd_type_d;
  logic [BA_W-1:0]   cmd_ba_q, cmd_ba_d;
  logic [ADDR_W-1:0] cmd_addr_q, cmd_addr_d;
  logic [BA_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [CNT_W-1:0]  rrd_q, rrd_d;
  logic [CNT_W-1:0]  ccd_q, ccd_d;

  // Split the flat request buses and classify each pending command.
  for (genvar gi = 0; gi < BK_CNT; gi++) begin : g_bank
    assign cmd_arr[gi]  = bus.req_cmd[2*gi +: 2];
    assign addr_arr[gi] = bus.req_addr[ADDR_W*gi +: ADDR_W];
    assign act_req[gi]  = bus.req_valid[gi] & (cmd_arr[gi] == CMD_ACT) & act_ok;
    assign col_req[gi]  = bus.req_valid[gi] & ((cmd_arr[gi] == CMD_RD) |
                                               (cmd_arr[gi] == CMD_WR)) & col_ok;
    assign pre_req[gi]  = bus.req_valid[gi] & (cmd_arr[gi] == CMD_PRE);
  end

  assign col_ok = (ccd_q == '0);

`ifdef SAL_TFAW_EN
  logic [CNT_W-1:0] faw_q [4];
  logic [CNT_W-1:0] faw_d [4];
  logic             faw_free;

  // A FAW slot is free when any of the four window counters has expired;
  // an ACT grant claims the lowest-index free slot.
  always_comb begin
    faw_free = 1'b0;
    for (int k = 0; k < 4; k++) begin
      if (faw_q[k] == '0) faw_free = 1'b1;
    end
    for (int k = 0; k < 4; k++) begin
      faw_d[k] = (faw_q[k] != '0) ? faw_q[k] - 1'b1 : faw_q[k];
    end
    if (act_g) begin
      for (int k = 3; k >= 0; k--) begin
        if (faw_q[k] == '0) begin
          faw_d = faw_q;
          for (int j = 0; j < 4; j++) begin
            faw_d[j] = (faw_q[j] != '0) ? faw_q[j] - 1'b1 : faw_q[j];
          end
          faw_d[k] = CNT_W'(TFAW - 1);
        end
      end
    end
  end

  assign act_ok = (rrd_q == '0) & faw_free;
`else
  assign act_ok = (rrd_q == '0);
`endif

  // Only the highest non-empty eligible class reaches the arbiter.
  always_comb begin
    if (|col_req)      sel_req = col_req;
    else if (|pre_req) sel_req = pre_req;
    else               sel_req = act_req;
  end

  sal_rr_arbiter #(.N(BK_CNT), .IW(BA_W)) u_arb (
    .req_i (sel_req),
    .ptr_i (rr_ptr_q),
    .gnt_o (arb_gnt),
    .idx_o (arb_idx),
    .any_o (arb_any)
  );

  assign bus.req_gnt = rst_n ? arb_gnt : '0;
  assign act_g = arb_any & (cmd_arr[arb_idx] == CMD_ACT);
  assign col_g = arb_any & ((cmd_arr[arb_idx] == CMD_RD) | (cmd_arr[arb_idx] == CMD_WR));

  // Next-state: bus command, pointer advance and timer load/decrement.
  always_comb begin
    cmd_valid_d = arb_any;
    cmd_type_d  = arb_any ? cmd_arr[arb_idx] : 2'd0;
    cmd_ba_d    = arb_any ? arb_idx : '0;
    cmd_addr_d  = arb_any ? addr_arr[arb_idx] : '0;
    rr_ptr_d    = rr_ptr_q;
    if (arb_any) begin
      rr_ptr_d = (arb_idx == BA_W'(BK_CNT - 1)) ? '0 : arb_idx + BA_W'(1);
    end
    rrd_d = (rrd_q != '0) ? rrd_q - 1'b1 : rrd_q;
    if (act_g) rrd_d = CNT_W'(TRRD - 1);
    ccd_d = (ccd_q != '0) ? ccd_q - 1'b1 : ccd_q;
    if (col_g) ccd_d = CNT_W'(TCCD - 1);
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cmd_valid_q <= 1'b0;
      cmd_type_q  <= 2'd0;
      cmd_ba_q    <= '0;
      cmd_addr_q  <= '0;
      rr_ptr_q    <= '0;
      rrd_q       <= '0;
      ccd_q       <= '0;
`ifdef SAL_TFAW_EN
      for (int k = 0; k < 4; k++) faw_q[k] <= '0;
`endif
    end else begin
      cmd_valid_q <= cmd_valid_d;
      cmd_type_q  <= cmd_type_d;
      cmd_ba_q    <= cmd_ba_d;
      cmd_addr_q  <= cmd_addr_d;
      rr_ptr_q    <= rr_ptr_d;
      rrd_q       <= rrd_d;
      ccd_q       <= ccd_d;
`ifdef SAL_TFAW_EN
      for (int k = 0; k < 4; k++) faw_q[k] <= faw_d[k];
`endif
    end
  end

  assign bus.cmd_valid = cmd_valid_q;
  assign bus.cmd_type  = cmd_type_q;
  assign bus.cmd_ba    = cmd_ba_q;
  assign bus.cmd_addr  = cmd_addr_q;
endmodule

// File: tb/tb_sal_cmd_scheduler.sv
// Directed testbench for sal_cmd_scheduler (TRRD=2, TCCD=2, TFAW=10).
// Expected bus commands are queued when a grant is expected and compared
// one cycle later. Honours SAL_TFAW_EN for the fifth-ACT timing.
module tb_sal_cmd_scheduler;
  import sal_ddr2_pkg::*;

  localparam int BK = 8;
  localparam int AW = 14;

  typedef struct packed {
    logic          v;
    logic [1:0]    t;
    logic [2:0]    ba;
    logic [AW-1:0] addr;
  } ent_t;

  localparam ent_t IDLE = '0;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  sal_cmd_scheduler_if #(.BK_CNT(BK), .ADDR_W(AW)) bus ();

  sal_cmd_scheduler #(
    .BK_CNT(BK), .ADDR_W(AW), .TRRD(2), .TCCD(2), .TFAW(10)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  logic          v [BK];
  logic [1:0]    c [BK];
  logic [AW-1:0] a [BK];
  ent_t          q [$];
  int            total = 0;
  int            bad   = 0;

  task automatic drive();
    for (int i = 0; i < BK; i++) begin
      bus.req_valid[i]          = v[i];
      bus.req_cmd[2*i +: 2]     = c[i];
      bus.req_addr[AW*i +: AW]  = a[i];
    end
  endtask

  task automatic req(input int b, input logic [1:0] cmd, input logic [AW-1:0] ad);
    v[b] = 1'b1;
    c[b] = cmd;
    a[b] = ad;
  endtask

  // One clock cycle: check the grant, check last cycle's bus command,
  // queue this cycle's expected command, then retire/re-present the grantee.
  task automatic cyc(input string tag, input logic [BK-1:0] exp, input bit rep = 1'b0);
    ent_t got, want;
    int   idx;
    @(negedge clk);
    total++;
    assert (bus.req_gnt === exp) else begin
      bad++;
      $error("FAIL %s gnt: observed=%b expected=%b", tag, bus.req_gnt, exp);
    end
    want = (q.size() > 0) ? q.pop_front() : IDLE;
    got  = {bus.cmd_valid, bus.cmd_type, bus.cmd_ba, bus.cmd_addr};
    total++;
    assert (got === want) else begin
      bad++;
      $error("FAIL %s bus: observed v=%b t=%0d ba=%0d a=%h expected v=%b t=%0d ba=%0d a=%h",
             tag, got.v, got.t, got.ba, got.addr, want.v, want.t, want.ba, want.addr);
    end
    idx = -1;
    for (int i = 0; i < BK; i++) if (exp[i]) idx = i;
    if (idx >= 0) q.push_back({1'b1, c[idx], 3'(idx), a[idx]});
    else          q.push_back(IDLE);
    $display("cyc %-10s gnt=%b bus v=%b t=%0d ba=%0d a=%h", tag, bus.req_gnt,
             got.v, got.t, got.ba, got.addr);
    @(posedge clk);
    #1;
    if (idx >= 0) begin
      if (rep) a[idx] = a[idx] + 1'b1;
      else     v[idx] = 1'b0;
    end
    drive();
  endtask

  task automatic rst_pulse(input string tag);
    rst_n = 1'b0;
    cyc(tag, '0);
    rst_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < BK; i++) begin
      v[i] = 1'b0; c[i] = 2'd0; a[i] = '0;
    end
    // Initial reset with a PRE pending: grant must stay 0, bus idle.
    req(4, CMD_PRE, '0);
    drive();
    @(posedge clk);
    #1;
    q.push_back(IDLE);
    cyc("rst", '0);
    rst_n = 1'b1;
    v[4] = 1'b0;
    drive();

    // Single RD from bank 3.
    req(3, CMD_RD, 14'h012);
    drive();
    cyc("t1_rd", 8'h08);
    cyc("t1_idle", '0);

    // Two RDs with rr_ptr=0 and TCCD=2.
    rst_pulse("t2_rst");
    req(1, CMD_RD, 14'h100);
    req(5, CMD_RD, 14'h105);
    drive();
    cyc("t2_rd1", 8'h02);
    cyc("t2_gap", '0);
    cyc("t2_rd5", 8'h20);
    cyc("t2_idle", '0);

    // PRE beats ACT.
    req(2, CMD_ACT, 14'h222);
    req(4, CMD_PRE, '0);
    drive();
    cyc("t3_pre", 8'h10);
    cyc("t3_act", 8'h04);
    cyc("t3_idle", '0);

    // Column blocked by tCCD lets PRE through; rr pointer wraps.
    req(0, CMD_RD, 14'h010);
    req(1, CMD_WR, 14'h011);
    req(6, CMD_PRE, '0);
    drive();
    cyc("t3b_rd0", 8'h01);
    cyc("t3b_pre6", 8'h40);
    cyc("t3b_wr1", 8'h02);
    cyc("t3b_idle", '0);

    // ACT spacing by tRRD (and tFAW when enabled).
    rst_pulse("t4_rst");
    for (int i = 0; i < 5; i++) req(i, CMD_ACT, 14'h300 + 14'(i));
    drive();
    cyc("t4_act0", 8'h01);
    cyc("t4_gap", '0);
    cyc("t4_act1", 8'h02);
    cyc("t4_gap", '0);
    cyc("t4_act2", 8'h04);
    cyc("t4_gap", '0);
    cyc("t4_act3", 8'h08);
`ifdef SAL_TFAW_EN
    cyc("t4_faw", '0);
    cyc("t4_faw", '0);
    cyc("t4_faw", '0);
`else
    cyc("t4_gap", '0);
`endif
    cyc("t4_act4", 8'h10);
    for (int i = 0; i < 11; i++) cyc("t4_drain", '0);

    // Continuous RD from all banks: fair rotation every TCCD cycles.
    rst_pulse("t5_rst");
    for (int i = 0; i < BK; i++) req(i, CMD_RD, 14'h400 + 14'(16 * i));
    drive();
    for (int i = 0; i < 9; i++) begin
      cyc("t5_rd", 8'(1 << (i % BK)), 1'b1);
      if (i < 8) cyc("t5_gap", '0, 1'b1);
    end
    for (int i = 0; i < BK; i++) v[i] = 1'b0;
    drive();
    cyc("t5_end", '0);
    cyc("t5_idle", '0);

    // Mid-stream reset with rrd and rr_ptr nonzero.
    req(5, CMD_ACT, 14'h555);
    drive();
    cyc("t6_act5", 8'h20);
    req(2, CMD_ACT, 14'h002);
    req(7, CMD_ACT, 14'h007);
    req(4, CMD_PRE, '0);
    rst_n = 1'b0;
    drive();
    cyc("t6_rst", '0);
    rst_n = 1'b1;
    v[4] = 1'b0;
    drive();
    cyc("t6_act2", 8'h04);
    cyc("t6_gap", '0);
    cyc("t6_act7", 8'h80);
    cyc("t6_end", '0);
    cyc("t6_idle", '0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
